gfp8_nv_dot_sched: RTL
======================

// Module: gfp8_nv_dot_sched
// PURPOSE
//  Sequences the GFP8 native-vector dot unit for one K-reduction: accepts a command (left/right NV base
//  addresses, NV count), issues one BRAM read per cycle, strobes the dot unit's input valid in step with
//  the read data, and tracks in-flight results with a latency shift register. Returned per-NV GFP results
//  are exponent-aligned and accumulated into one GFP result, presented on a valid/ready port.
//  Sits between the tile BRAM and the dot unit; the BRAM-to-dot data buses bypass this block.
// PARAMETERS
//  ADDR_W       9   NV address width (left and right BRAM)
//  CNT_W        9   NV count width
//  RD_LAT       1   BRAM read latency, cycles from o_rd_en to data valid at the dot inputs
//  DOT_LATENCY  4   cycles from o_dot_input_valid to the dot result being valid on its outputs
// PORTS
//  i_clk              in   1       clock
//  i_reset            in   1       asynchronous, active-high reset
//  i_cmd_valid        in   1       command valid
//  o_cmd_ready        out  1       command accepted when valid&ready; high only in IDLE
//  i_cmd_left_addr    in   ADDR_W  first left NV address
//  i_cmd_right_addr   in   ADDR_W  first right NV address
//  i_cmd_num_nv       in   CNT_W   NVs to reduce (0 allowed)
//  o_rd_en            out  1       BRAM read strobe (left and right together)
//  o_rd_left_addr     out  ADDR_W  left read address
//  o_rd_right_addr    out  ADDR_W  right read address
//  o_dot_input_valid  out  1       dot unit input valid
//  i_dot_mantissa     in   32      dot result mantissa (signed)
//  i_dot_exponent     in   8       dot result exponent (signed)
//  o_res_valid        out  1       accumulated result valid
//  i_res_ready        in   1       downstream accepts the result
//  o_res_mantissa     out  32      accumulated mantissa (signed)
//  o_res_exponent     out  8       accumulated exponent (signed)
//  o_busy             out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset: state IDLE; counters, shift register and accumulator cleared; o_cmd_ready=1; o_rd_en=0,
//   o_dot_input_valid=0, o_res_valid=0, o_res_mantissa=0, o_res_exponent=0, addresses 0, o_busy=0.
//   Reset mid-operation discards every in-flight result; no later pulse leaks onto o_res_valid.
//  FSM IDLE -> ISSUE on accept with num_nv>0; IDLE -> DONE on accept with num_nv==0 (result 0 / exp 0).
//   ISSUE: o_rd_en=1 every cycle, addresses start at the command bases, +1 per cycle, wrap modulo 2^ADDR_W;
//   after num_nv reads -> DRAIN. DRAIN -> DONE in the cycle the last result is accumulated.
//   DONE: o_res_valid held with stable data until i_res_ready; -> IDLE on the valid&ready cycle.
//  Timing: o_dot_input_valid = o_rd_en delayed RD_LAT cycles. Result-capture strobe = o_dot_input_valid
//   delayed DOT_LATENCY cycles (shift register, depth RD_LAT+DOT_LATENCY); dot outputs sampled on it.
//   Back-to-back issue is the only supported mode (dot unit fully pipelined, one NV per cycle).
//  Command latency: o_res_valid rises RD_LAT+DOT_LATENCY+num_nv+1 cycles after the accept cycle.
//  Accumulate, one strobe per cycle: first strobe loads acc directly. Later strobes: e_max=max(acc_e,res_e);
//   operand with smaller exponent arithmetic-right-shifted by the difference (diff>31 -> 0, sign kept);
//   sum saturates to signed 32-bit (0x7FFFFFFF / 0x80000000); acc_e=e_max. No renormalisation.
//  Exponent compare is signed 8-bit; equal exponents: no shift.
//  i_cmd_valid outside IDLE: ignored (not queued). i_res_ready outside DONE: ignored.
// STRUCTURE
//  gfp8_pkg: sched_state_e {IDLE,ISSUE,DRAIN,DONE}; GFP_MAN_W=32, GFP_EXP_W=8, ALIGN_ZERO_THRESH=31,
//   saturation constants.
//  Sub-module gfp_acc_align: combinational align + saturating add of two GFP operands, so the same
//   operator serves the dot unit's group reduction later.
// TESTING
//  num_nv=1, dot returns (m=100,e=5) -> o_res_valid after RD_LAT+DOT_LATENCY+2 cycles, (100,5).
//  num_nv=3, returns (8,2),(8,4),(-4,4) -> (2+8-4=6, 4); exactly 3 read strobes, addrs base..base+2.
//  Exp gap: (1000,0) then (1,40) -> (1,40) (diff 40>31 zeroes the 1000).
//  Saturation: (0x7FFFFFF0,3) twice -> (0x7FFFFFFF,3); negative pair -> 0x80000000.
//  num_nv=0 -> o_res_valid 1 cycle after accept, (0,0); i_res_ready held low 10 cycles -> data stable,
//   o_cmd_ready low throughout.
//  Reset asserted mid-DRAIN and released -> IDLE, no o_res_valid; left base 0x1FF, num_nv=2 -> addrs 0x1FF,0x000.

Source files
------------

// File: rtl/gfp8_pkg.sv
// Shared GFP8 types and constants for the dot-unit scheduler and its accumulator.
package gfp8_pkg;

   localparam int GFP_MAN_W         = 32;
   localparam int GFP_EXP_W         = 8;
   localparam int ALIGN_ZERO_THRESH = 31;

   // Saturation limits for the signed 32-bit accumulated mantissa
   localparam logic signed [GFP_MAN_W-1:0] GFP_MAN_MAX = 32'sh7FFF_FFFF;
   localparam logic signed [GFP_MAN_W-1:0] GFP_MAN_MIN = 32'sh8000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } sched_state_e;

endpackage

// File: rtl/gfp_acc_align.sv
// Combinational GFP align + saturating add: the operand with the smaller exponent is
// arithmetic-right-shifted to the larger exponent, then the mantissas are summed with
// signed 32-bit saturation. No renormalisation is applied.
module gfp_acc_align
   import gfp8_pkg::*;
(
   input  logic signed [GFP_MAN_W-1:0] a_man_i,
   input  logic signed [GFP_EXP_W-1:0] a_exp_i,
   input  logic signed [GFP_MAN_W-1:0] b_man_i,
   input  logic signed [GFP_EXP_W-1:0] b_exp_i,
   output logic signed [GFP_MAN_W-1:0] sum_man_o,
   output logic signed [GFP_EXP_W-1:0] sum_exp_o
);

   logic                        a_big;
   logic [GFP_EXP_W:0]          a_exp_x;
   logic [GFP_EXP_W:0]          b_exp_x;
   logic [GFP_EXP_W:0]          diff;
   logic signed [GFP_MAN_W-1:0] big_man;
   logic signed [GFP_MAN_W-1:0] small_man;
   logic signed [GFP_MAN_W-1:0] small_shifted;
   logic signed [GFP_MAN_W:0]   sum_wide;

   // Pick the larger exponent, align the other mantissa and add with saturation
   always_comb begin
      a_big   = (a_exp_i >= b_exp_i);
      a_exp_x = {a_exp_i[GFP_EXP_W-1], a_exp_i};
      b_exp_x = {b_exp_i[GFP_EXP_W-1], b_exp_i};
      // Modular subtraction of sign-extended exponents yields the non-negative gap
      diff      = a_big ? (a_exp_x - b_exp_x) : (b_exp_x - a_exp_x);
      big_man   = a_big ? a_man_i : b_man_i;
      small_man = a_big ? b_man_i : a_man_i;
      if (diff > (GFP_EXP_W+1)'(ALIGN_ZERO_THRESH)) begin
         small_shifted = '0;
      end else begin
         small_shifted = small_man >>> diff[4:0];
      end
      sum_wide = {big_man[GFP_MAN_W-1], big_man} + {small_shifted[GFP_MAN_W-1], small_shifted};
      if (sum_wide[GFP_MAN_W] != sum_wide[GFP_MAN_W-1]) begin
         sum_man_o = sum_wide[GFP_MAN_W] ? GFP_MAN_MIN : GFP_MAN_MAX;
      end else begin
         sum_man_o = sum_wide[GFP_MAN_W-1:0];
      end
      sum_exp_o = a_big ? a_exp_i : b_exp_i;
   end

endmodule

// File: rtl/gfp8_nv_dot_sched.sv
// Sequences one K-reduction on the GFP8 native-vector dot unit: issues back-to-back BRAM
// reads, strobes the dot unit's input valid in step with the read data, captures each dot
// result after the pipeline latency and accumulates them into one GFP result.
module gfp8_nv_dot_sched
   import gfp8_pkg::*;
#(
   parameter int ADDR_W      = 9,
   parameter int CNT_W       = 9,
   parameter int RD_LAT      = 1,
   parameter int DOT_LATENCY = 4
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_cmd_valid,
   output logic                        o_cmd_ready,
   input  logic [ADDR_W-1:0]           i_cmd_left_addr,
   input  logic [ADDR_W-1:0]           i_cmd_right_addr,
   input  logic [CNT_W-1:0]            i_cmd_num_nv,
   output logic                        o_rd_en,
   output logic [ADDR_W-1:0]           o_rd_left_addr,
   output logic [ADDR_W-1:0]           o_rd_right_addr,
   output logic                        o_dot_input_valid,
   input  logic signed [GFP_MAN_W-1:0] i_dot_mantissa,
   input  logic signed [GFP_EXP_W-1:0] i_dot_exponent,
   output logic                        o_res_valid,
   input  logic                        i_res_ready,
   output logic signed [GFP_MAN_W-1:0] o_res_mantissa,
   output logic signed [GFP_EXP_W-1:0] o_res_exponent,
   output logic                        o_busy
);

   // One tap per cycle from read strobe to result capture
   localparam int PIPE_D = RD_LAT + DOT_LATENCY;

   sched_state_e                state_q, state_d;
   logic [CNT_W-1:0]            iss_cnt_q;
   logic [CNT_W-1:0]            res_cnt_q;
   logic [ADDR_W-1:0]           left_q;
   logic [ADDR_W-1:0]           right_q;
   logic [PIPE_D-1:0]           pipe_q;
   logic signed [GFP_MAN_W-1:0] acc_man_q;
   logic signed [GFP_EXP_W-1:0] acc_exp_q;
   logic                        first_q;
   logic signed [GFP_MAN_W-1:0] sum_man;
   logic signed [GFP_EXP_W-1:0] sum_exp;
   logic                        cmd_acc;
   logic                        rd_en;
   logic                        strobe;

   assign cmd_acc = i_cmd_valid && (state_q == IDLE);
   assign rd_en   = (state_q == ISSUE);
   assign strobe  = pipe_q[PIPE_D-1];

   assign o_cmd_ready       = (state_q == IDLE);
   assign o_busy            = (state_q != IDLE);
   assign o_res_valid       = (state_q == DONE);
   assign o_rd_en           = rd_en;
   assign o_rd_left_addr    = left_q;
   assign o_rd_right_addr   = right_q;
   assign o_dot_input_valid = pipe_q[RD_LAT-1];
   assign o_res_mantissa    = acc_man_q;
   assign o_res_exponent    = acc_exp_q;

   // Next-state logic; DRAIN ends on the strobe that carries the final outstanding result
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (cmd_acc) state_d = (i_cmd_num_nv == '0) ? DONE : ISSUE;
         ISSUE: if (iss_cnt_q == CNT_W'(1)) state_d = DRAIN;
         DRAIN: if (strobe && (res_cnt_q == CNT_W'(1))) state_d = DONE;
         DONE:  if (i_res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Read issue counter and wrapping read addresses
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         iss_cnt_q <= '0;
         left_q    <= '0;
         right_q   <= '0;
      end else if (cmd_acc) begin
         iss_cnt_q <= i_cmd_num_nv;
         left_q    <= i_cmd_left_addr;
         right_q   <= i_cmd_right_addr;
      end else if (rd_en) begin
         iss_cnt_q <= iss_cnt_q - CNT_W'(1);
         left_q    <= left_q + ADDR_W'(1);
         right_q   <= right_q + ADDR_W'(1);
      end
   end

   // In-flight tracker: read strobe delayed through BRAM and dot-unit latency
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) pipe_q <= '0;
      else         pipe_q <= {pipe_q[PIPE_D-2:0], rd_en};
   end

   gfp_acc_align u_align (
      .a_man_i   (acc_man_q),
      .a_exp_i   (acc_exp_q),
      .b_man_i   (i_dot_mantissa),
      .b_exp_i   (i_dot_exponent),
      .sum_man_o (sum_man),
      .sum_exp_o (sum_exp)
   );

   // Accumulator: the first captured result loads directly, later ones align-and-add
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         acc_man_q <= '0;
         acc_exp_q <= '0;
         first_q   <= 1'b0;
         res_cnt_q <= '0;
      end else if (cmd_acc) begin
         acc_man_q <= '0;
         acc_exp_q <= '0;
         first_q   <= 1'b1;
         res_cnt_q <= i_cmd_num_nv;
      end else if (strobe) begin
         first_q   <= 1'b0;
         res_cnt_q <= res_cnt_q - CNT_W'(1);
         acc_man_q <= first_q ? i_dot_mantissa : sum_man;
         acc_exp_q <= first_q ? i_dot_exponent : sum_exp;
      end
   end

endmodule
